// File: rtl/int_datapath_pipe.sv
// SIMD integer datapath: single op, fused multiply-add, accumulate-reduce.
// Define INT_DATAPATH_FLAGS_EN to add the per-lane {Z,N,C,V} O_Flags output.
module int_datapath_pipe #(
  parameter int WIDTH_DATA = 32,
  parameter int NUM_LANE   = 2,
  parameter int DEPTH_PIPE = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           I_Active,
  input  logic                           I_Valid,
  input  logic [3:0]                     I_Opcode,
  input  logic [1:0]                     I_Mode,
  input  logic                           I_Last,
  input  logic                           I_SelImm,
  input  logic [7:0]                     I_Imm,
  input  logic [NUM_LANE*WIDTH_DATA-1:0] I_OperandA,
  input  logic [NUM_LANE*WIDTH_DATA-1:0] I_OperandB,
  input  logic [NUM_LANE*WIDTH_DATA-1:0] I_OperandC,
  output logic                           O_Nack,
  output logic                           O_Valid,
  output logic [NUM_LANE*WIDTH_DATA-1:0] O_Result,
`ifdef INT_DATAPATH_FLAGS_EN
  input  logic                           I_Nack,
  output logic [NUM_LANE*4-1:0]          O_Flags
`else
  input  logic                           I_Nack
`endif
);

  localparam int W  = WIDTH_DATA;
  localparam int L  = NUM_LANE;
  localparam int D  = DEPTH_PIPE;
  localparam int SH = $clog2(W);
  localparam int LW = L * W;
  localparam int NP = (D > 1) ? D - 1 : 1;

  typedef struct packed {
    logic          vld;
    logic [1:0]    mode;
    logic          last;
    logic [LW-1:0] val;
    logic [LW-1:0] c;
`ifdef INT_DATAPATH_FLAGS_EN
    logic [2*L-1:0] cv;
`endif
  } tok_t;

  tok_t ent  [D];
  tok_t pipe [NP];
  tok_t fin;

  logic [W-1:0] acc [L];
  logic [W-1:0] sum [L];

  function automatic logic [W-1:0] alu(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [SH-1:0]  sh;
    logic [2*W-1:0] rot;
    sh  = b[SH-1:0];
    rot = {a, a} << sh;
    alu = a;
    case (op)
      4'd0:  alu = a + b;
      4'd1:  alu = a - b;
      4'd2:  alu = a * b;
      4'd3:  alu = a & b;
      4'd4:  alu = a | b;
      4'd5:  alu = a ^ b;
      4'd6:  alu = a << sh;
      4'd7:  alu = a >> sh;
      4'd8:  alu = $signed(a) >>> sh;
      4'd9:  alu = rot[2*W-1:W];
      4'd10: alu = ($signed(a) < $signed(b)) ? a : b;
      4'd11: alu = ($signed(a) > $signed(b)) ? a : b;
      default: alu = a;
    endcase
  endfunction

`ifdef INT_DATAPATH_FLAGS_EN
  function automatic logic [1:0] addsub_cv(
    input logic         sub,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0]   r;
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    addsub_cv = {r[W],
      (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1])};
  endfunction
`endif

  assign O_Nack = I_Nack & reset;

  always_comb begin
    logic [W-1:0] a, b, c, v;
    ent[0]      = '0;
    ent[0].vld  = I_Active & I_Valid & ~I_Nack;
    ent[0].mode = (I_Mode == 2'd3) ? 2'd0 : I_Mode;
    ent[0].last = I_Last;
    ent[0].c    = I_OperandC;
    for (int l = 0; l < L; l++) begin
      a = I_OperandA[l*W +: W];
      b = I_SelImm ? WIDTH_DATA'(I_Imm)
                   : I_OperandB[l*W +: W];
      c = I_OperandC[l*W +: W];
      if (ent[0].mode == 2'd1) begin
        v = a * b;
        if (D == 1) v = v + c;
      end else begin
        v = alu(I_Opcode, a, b);
      end
      ent[0].val[l*W +: W] = v;
`ifdef INT_DATAPATH_FLAGS_EN
      if (ent[0].mode == 2'd0 && I_Opcode[3:1] == 3'd0)
        ent[0].cv[2*l +: 2] = addsub_cv(I_Opcode[0], a, b);
`endif
    end
    // The C term of a fused token joins in stage 2
    for (int k = 1; k < D; k++) begin
      ent[k] = pipe[k-1];
      if (k == 1 && pipe[0].mode == 2'd1)
        for (int l = 0; l < L; l++)
          ent[k].val[l*W +: W] = pipe[0].val[l*W +: W]
                               + pipe[0].c[l*W +: W];
    end
  end

  assign fin = ent[D-1];

  always_comb begin
    for (int l = 0; l < L; l++)
      sum[l] = acc[l] + fin.val[l*W +: W];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NP; k++) pipe[k] <= '0;
    end else if (!I_Nack) begin
      for (int k = 0; k < D - 1; k++) pipe[k] <= ent[k];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      O_Valid  <= 1'b0;
      O_Result <= '0;
      for (int l = 0; l < L; l++) acc[l] <= '0;
    end else if (!I_Nack) begin
      O_Valid <= fin.vld & ((fin.mode != 2'd2) | fin.last);
      if (fin.vld) begin
        for (int l = 0; l < L; l++) begin
          if (fin.mode != 2'd2) begin
            O_Result[l*W +: W] <= fin.val[l*W +: W];
          end else if (fin.last) begin
            O_Result[l*W +: W] <= sum[l];
            acc[l] <= '0;
          end else begin
            acc[l] <= sum[l];
          end
        end
      end
    end
  end

`ifdef INT_DATAPATH_FLAGS_EN
  always_ff @(posedge clock or negedge reset) begin
    logic [W-1:0] r;
    logic [1:0]   cv;
    if (!reset) begin
      O_Flags <= '0;
    end else if (!I_Nack) begin
      if (fin.vld & ((fin.mode != 2'd2) | fin.last)) begin
        for (int l = 0; l < L; l++) begin
          if (fin.mode == 2'd2) begin
            r  = sum[l];
            cv = addsub_cv(1'b0, acc[l],
                           fin.val[l*W +: W]);
          end else begin
            r  = fin.val[l*W +: W];
            cv = fin.cv[2*l +: 2];
          end
          O_Flags[l*4 +: 4] <= {r == '0, r[W-1], cv};
        end
      end
    end
  end
`endif

endmodule

// File: doc/int_datapath_pipe.md
Name: int_datapath_pipe

Overview:
- Parametrised, pipelined successor of the integer datapath.
- NUM_LANE SIMD lanes share one opcode and one mode per token.
- Pipeline depth is configurable; global stall is driven by downstream nack.
- Three modes: single op, fused multiply-add, and accumulate-reduce with last-element flush. Sits between the operand-fetch stage and the result-routing stage of a compute element.

Parameters:
- WIDTH_DATA, 32, lane width in bits (8..64, power of 2).
- NUM_LANE, 2, number of parallel lanes (1..8).
- DEPTH_PIPE, 2, cycles from accept to O_Valid (1..4).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- I_Active  in  1  module enable; 0 = no new accepts, the pipe still drains.
- I_Valid  in  1  input token valid.
- I_Opcode  in  4  operation, captured per token.
- I_Mode  in  2  0=single, 1=fused A*B+C, 2=accumulate, 3=reserved (treated as 0).
- I_Last  in  1  last element of an accumulate group.
- I_SelImm  in  1  replace operand B of every lane with the zero-extended I_Imm.
- I_Imm  in  8  immediate value.
- I_OperandA  in  NUM_LANE*WIDTH_DATA  lane i occupies bits [i*W +: W].
- I_OperandB  in  NUM_LANE*WIDTH_DATA  same lane packing.
- I_OperandC  in  NUM_LANE*WIDTH_DATA  same lane packing; used only in mode 1.
- O_Nack  out  1  backpressure to upstream.
- O_Valid  out  1  result valid.
- O_Result  out  NUM_LANE*WIDTH_DATA  result, same lane packing.
- I_Nack  in  1  downstream backpressure.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits = 0; accumulators = 0.
  - O_Valid = 0, O_Result = 0, O_Nack = 0.
  - A reset mid-group discards the partial accumulation.
- Accept: occurs when I_Active & I_Valid & ~O_Nack. Opcode, mode and last travel with the data through every stage.
- Backpressure:
  - O_Nack = I_Nack.
  - While I_Nack=1, every stage register holds. O_Valid and O_Result are stable and no accumulator update occurs.
  - No bubble collapsing.
- Latency: exactly DEPTH_PIPE clock edges from accept to O_Valid when I_Nack stays 0. Throughput is 1 token per cycle.
- Stage map:
  - Stage 1 registers the operands and computes the op.
  - Extra stages are pure delay.
  - Mode 1 adds the C term in stage 2 when DEPTH_PIPE >= 2, otherwise in stage 1.
  - Latency is unchanged by mode.
- Opcodes (per lane; all arithmetic modulo 2^W, no saturation):
  - 0 ADD, 1 SUB (A-B), 2 MUL (low W bits).
  - 3 AND, 4 OR, 5 XOR.
  - 6 SLL, 7 SRL, 8 SRA, 9 ROL. Shift amount = B[log2(W)-1:0].
  - 10 MIN signed, 11 MAX signed.
  - 12..15 PASS A.
- Mode 1: result = low W bits of (A*B) + C. The opcode field is ignored.
- Mode 2 (per-lane accumulator ACC, updated at the final stage):
  - Token with last=0: ACC <= ACC + op(A,B); no O_Valid.
  - Token with last=1: O_Result = ACC + op(A,B), O_Valid=1, ACC <= 0.
  - Group of length 1 (first token has last=1): outputs op(A,B).
- Mode switch inside an open group:
  - A mode 0/1 token passes through without disturbing ACC.
  - The group continues with the next mode 2 token.
- I_Active=0: in-flight tokens complete normally.
- Stall and last in the same cycle: the update is deferred until the stall releases; the flush still happens exactly once.
- O_Result holds its last value when O_Valid=0.

Optional Feature:
- Macro: INT_DATAPATH_FLAGS_EN.
- Defined:
  - Adds output port O_Flags, width NUM_LANE*4, per lane {Z,N,C,V}.
  - Flags are computed on the final result and aligned with O_Valid.
  - C and V are meaningful for ADD, SUB and the accumulate flush; otherwise they are 0.
  - Flags are held under stall and reset to 0.
- Not defined: no O_Flags port and no flag logic.

Test Plan:
- Reset, then NUM_LANE=2, W=32, DEPTH_PIPE=2, ADD with A={5,0xFFFFFFFF}, B={3,1} -> O_Valid exactly 2 cycles after accept, O_Result={8,0}.
- SRA with A=0x80000000, SelImm=1, Imm=4 -> 0xF8000000. ROL with A=0x80000001, B=1 -> 0x00000003.
- Mode 1, A=7, B=6, C=-2 (0xFFFFFFFE) -> 40. Back-to-back with a mode 0 SUB 3-5 -> next cycle 0xFFFFFFFE.
- Mode 2, ADD of pairs (1,1),(2,2),(3,3 last) -> single O_Valid with 12. Next group of one (4,0 last) -> 4.
- I_Nack=1 for 3 cycles while O_Valid=1 with 5 tokens streaming:
  - O_Result is held and O_Nack=1.
  - On release, all 5 results appear in order with no loss or duplicate.
- Reset asserted mid-group after 2 of 3 accumulate tokens -> O_Valid=0 immediately. A new group (10,0 last) -> 10.
